// File: rtl/fifo_ff_rd_stream_pkg.sv
// Shared constants and types for the flip-flop FIFO read-side stream adapter.
package fifo_ff_pkg;

    localparam int FIFO_FF_DUT_WIDTH    = 8;
    localparam int FIFO_FF_RD_BUF_DEPTH = 2;

    typedef logic [1:0] fifo_ff_cnt_t;

endpackage

// File: rtl/fifo_ff_rd_stream_skid_buf.sv
// Two-entry register-file output buffer with wrapping 1-bit pointers, a word count
// and a synchronous clear that empties it without touching the stored words.
module fifo_ff_skid_buf
    import fifo_ff_pkg::*;
#(
    parameter int WIDTH = FIFO_FF_DUT_WIDTH
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid,
    output logic [1:0]       o_cnt
);

    logic [WIDTH-1:0] r_slot [FIFO_FF_RD_BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    fifo_ff_cnt_t     r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_FF_RD_BUF_DEPTH; i++) begin
                r_slot[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_wr_en) begin
                r_slot[r_wr_ptr] <= i_wr_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_rd_en) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous write and read leaves the count unchanged.
            r_cnt <= r_cnt + {1'b0, i_wr_en} - {1'b0, i_rd_en};
        end
    end

    // A write never targets the head slot while the buffer is non-empty,
    // so the head word is stable for as long as the consumer stalls.
    assign o_rd_data = r_slot[r_rd_ptr];
    assign o_valid   = (r_cnt != 2'd0);
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/fifo_ff_rd_stream.sv
// Read-side adapter for the flip-flop FIFOs: issues rd_en from the empty flag and
// presents the read port as a valid/ready stream through a 2-entry buffer.
module fifo_ff_rd_stream
    import fifo_ff_pkg::*;
#(
    parameter int WIDTH  = FIFO_FF_DUT_WIDTH,
    parameter int RD_LAT = 1
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_rd_data,
    output logic             o_fifo_rd_en,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready,
    output logic [1:0]       o_buf_cnt
);

    fifo_ff_cnt_t w_cnt;
    logic         w_pop;
    logic         w_land;
    logic         w_inflight;
    logic [2:0]   w_committed;

    // Stream handshake: a word transfers on every cycle where o_out_valid and
    // i_out_ready are both high; o_out_valid never drops and o_out_data never
    // changes while the consumer holds i_out_ready low.
    assign w_pop = o_out_valid & i_out_ready;

    // Slots already spoken for after this cycle's pop; the pop lookahead lets a
    // full buffer that is draining keep issuing one read per cycle.
    assign w_committed  = {1'b0, w_cnt} + {2'b00, w_inflight} - {2'b00, w_pop};
    assign o_fifo_rd_en = !i_rst && !i_flush && !i_fifo_empty && (w_committed < 3'd2);

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_inflight = 1'b0;
            assign w_land     = o_fifo_rd_en;
        end else begin : g_lat1
            logic r_inflight;

            always_ff @(posedge i_clk) begin
                if (i_rst || i_flush) begin
                    r_inflight <= 1'b0;
                end else begin
                    r_inflight <= o_fifo_rd_en;
                end
            end

            // A word arriving in a flush cycle belongs to the discarded stream.
            assign w_inflight = r_inflight;
            assign w_land     = r_inflight & !i_flush;
        end
    endgenerate

    fifo_ff_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_flush),
        .i_wr_en   (w_land),
        .i_wr_data (i_fifo_rd_data),
        .i_rd_en   (w_pop),
        .o_rd_data (o_out_data),
        .o_valid   (o_out_valid),
        .o_cnt     (w_cnt)
    );

    assign o_buf_cnt = w_cnt;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (({1'b0, w_cnt} + {2'b00, w_inflight}) <= 3'd2));

endmodule

// File: tb/tb_fifo_ff_rd_stream.sv
// Bench for fifo_ff_rd_stream: one adapter per read latency, each fed by a queue-based
// FIFO model, with outputs compared against the FIFO word order.
module tb_fifo_ff_rd_stream;
    import fifo_ff_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, flush = 1'b0, out_ready = 1'b0;
    logic         fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [W-1:0] fifo_data0 = '0, fifo_data1 = '0;
    logic         rd_en0, rd_en1, valid0, valid1;
    logic [W-1:0] data0, data1;
    logic [1:0]   cnt0, cnt1;

    logic [W-1:0] q0[$], q1[$];
    logic [W-1:0] got0[$], got1[$], exp0[$], exp1[$];
    int           gotc0[$], gotc1[$];
    int           cyc, n_checks, n_fail;
    int           re_cnt0, re_cnt1, re_first0, re_first1, stall_err0, stall_err1;
    logic         last_re0, last_re1;

    fifo_ff_rd_stream #(.WIDTH(W), .RD_LAT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_fifo_empty(fifo_empty0),
        .i_fifo_rd_data(fifo_data0), .o_fifo_rd_en(rd_en0), .o_out_valid(valid0),
        .o_out_data(data0), .i_out_ready(out_ready), .o_buf_cnt(cnt0));

    fifo_ff_rd_stream #(.WIDTH(W), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_fifo_empty(fifo_empty1),
        .i_fifo_rd_data(fifo_data1), .o_fifo_rd_en(rd_en1), .o_out_valid(valid1),
        .o_out_data(data1), .i_out_ready(out_ready), .o_buf_cnt(cnt1));

    // FIFO models: sync_c shows the head word combinationally, sync_r registers it on rd_en.
    function automatic void refresh();
        fifo_empty0 = (q0.size() == 0);
        fifo_empty1 = (q1.size() == 0);
        fifo_data0  = (q0.size() > 0) ? q0[0] : '0;
    endfunction

    function automatic void push_both(input logic [W-1:0] w);
        q0.push_back(w);
        q1.push_back(w);
        refresh();
    endfunction

    function automatic void clear_log();
        got0.delete(); got1.delete(); gotc0.delete(); gotc1.delete();
        re_cnt0 = 0; re_cnt1 = 0; re_first0 = -1; re_first1 = -1;
        stall_err0 = 0; stall_err1 = 0;
    endfunction

    // One clock cycle: log what the cycle did, then advance the FIFO models.
    task automatic tick();
        logic re0, re1, st0, st1;
        logic [W-1:0] pd0, pd1;
        #1;
        re0 = rd_en0; re1 = rd_en1;
        st0 = valid0 & !out_ready & !rst & !flush; pd0 = data0;
        st1 = valid1 & !out_ready & !rst & !flush; pd1 = data1;
        if (valid0 && out_ready) begin got0.push_back(data0); gotc0.push_back(cyc); end
        if (valid1 && out_ready) begin got1.push_back(data1); gotc1.push_back(cyc); end
        if (re0) begin re_cnt0++; if (re_first0 < 0) re_first0 = cyc; end
        if (re1) begin re_cnt1++; if (re_first1 < 0) re_first1 = cyc; end
        last_re0 = re0; last_re1 = re1;
        @(posedge clk);
        #1;
        cyc++;
        if (re0 && q0.size() > 0) void'(q0.pop_front());
        if (re1 && q1.size() > 0) fifo_data1 = q1.pop_front();
        refresh();
        if (st0 && !(valid0 && data0 === pd0)) stall_err0++;
        if (st1 && !(valid1 && data1 === pd1)) stall_err1++;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete(); refresh();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        q0.delete(); q1.delete();
        push_both(8'h5A);
        rst = 1'b1; out_ready = 1'b0; flush = 1'b0;
        #1;
        n_checks++; if (rd_en0 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en0 got %b exp 0", rd_en0); end
        n_checks++; if (rd_en1 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en1 got %b exp 0", rd_en1); end
        tick();
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid0 got %b exp 0", valid0); end
        n_checks++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1 got %b exp 0", valid1); end
        n_checks++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL reset_data0 got %h exp 00", data0); end
        n_checks++; if (data1 !== 8'h00) begin n_fail++; $display("FAIL reset_data1 got %h exp 00", data1); end
        n_checks++; if (cnt0 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt0 got %0d exp 0", cnt0); end
        n_checks++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    endtask

    task automatic test_stream();
        q0.delete(); q1.delete();
        for (int i = 1; i <= 8; i++) push_both(W'(i));
        clear_log();
        out_ready = 1'b1; rst = 1'b1; cyc = 0;
        tick();
        rst = 1'b0;
        repeat (13) tick();
        n_checks++; if (re_first0 != 1) begin n_fail++; $display("FAIL stream_first_rd_en_lat0 got %0d exp 1", re_first0); end
        n_checks++; if (re_first1 != 1) begin n_fail++; $display("FAIL stream_first_rd_en_lat1 got %0d exp 1", re_first1); end
        n_checks++; if (got0.size() != 8) begin n_fail++; $display("FAIL stream_count_lat0 got %0d exp 8", got0.size()); end
        n_checks++; if (got1.size() != 8) begin n_fail++; $display("FAIL stream_count_lat1 got %0d exp 8", got1.size()); end
        for (int i = 0; i < 8 && i < got0.size(); i++) begin
            n_checks++;
            if (got0[i] !== W'(i + 1) || gotc0[i] != 2 + i) begin
                n_fail++; $display("FAIL stream_word_lat0[%0d] got %h@%0d exp %h@%0d", i, got0[i], gotc0[i], i + 1, 2 + i);
            end
        end
        for (int i = 0; i < 8 && i < got1.size(); i++) begin
            n_checks++;
            if (got1[i] !== W'(i + 1) || gotc1[i] != 3 + i) begin
                n_fail++; $display("FAIL stream_word_lat1[%0d] got %h@%0d exp %h@%0d", i, got1[i], gotc1[i], i + 1, 3 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) push_both(8'h10 + W'(i));
        repeat (6) tick();
        n_checks++; if (re_cnt0 != 2) begin n_fail++; $display("FAIL bp_reads_lat0 got %0d exp 2", re_cnt0); end
        n_checks++; if (re_cnt1 != 2) begin n_fail++; $display("FAIL bp_reads_lat1 got %0d exp 2", re_cnt1); end
        n_checks++; if (cnt0 !== 2'd2) begin n_fail++; $display("FAIL bp_cnt_lat0 got %0d exp 2", cnt0); end
        n_checks++; if (cnt1 !== 2'd2) begin n_fail++; $display("FAIL bp_cnt_lat1 got %0d exp 2", cnt1); end
        n_checks++; if (data0 !== 8'h10) begin n_fail++; $display("FAIL bp_head_lat0 got %h exp 10", data0); end
        n_checks++; if (data1 !== 8'h10) begin n_fail++; $display("FAIL bp_head_lat1 got %h exp 10", data1); end
        n_checks++; if (stall_err0 != 0) begin n_fail++; $display("FAIL bp_stall_lat0 got %0d exp 0", stall_err0); end
        n_checks++; if (stall_err1 != 0) begin n_fail++; $display("FAIL bp_stall_lat1 got %0d exp 0", stall_err1); end
        out_ready = 1'b1;
        repeat (8) tick();
        n_checks++; if (got0.size() != 5) begin n_fail++; $display("FAIL bp_count_lat0 got %0d exp 5", got0.size()); end
        n_checks++; if (got1.size() != 5) begin n_fail++; $display("FAIL bp_count_lat1 got %0d exp 5", got1.size()); end
        for (int i = 0; i < 5 && i < got0.size(); i++) begin
            n_checks++; if (got0[i] !== 8'h10 + W'(i)) begin n_fail++; $display("FAIL bp_word_lat0[%0d] got %h exp %h", i, got0[i], 8'h10 + W'(i)); end
        end
        for (int i = 0; i < 5 && i < got1.size(); i++) begin
            n_checks++; if (got1[i] !== 8'h10 + W'(i)) begin n_fail++; $display("FAIL bp_word_lat1[%0d] got %h exp %h", i, got1[i], 8'h10 + W'(i)); end
        end
    endtask

    task automatic test_single_word();
        do_reset();
        push_both(8'hAA);
        out_ready = 1'b1;
        repeat (6) tick();
        n_checks++; if (re_cnt0 != 1) begin n_fail++; $display("FAIL single_reads_lat0 got %0d exp 1", re_cnt0); end
        n_checks++; if (re_cnt1 != 1) begin n_fail++; $display("FAIL single_reads_lat1 got %0d exp 1", re_cnt1); end
        n_checks++; if (got0.size() != 1 || got0[0] !== 8'hAA) begin n_fail++; $display("FAIL single_word_lat0 got %0d words exp 1 word AA", got0.size()); end
        n_checks++; if (got1.size() != 1 || got1[0] !== 8'hAA) begin n_fail++; $display("FAIL single_word_lat1 got %0d words exp 1 word AA", got1.size()); end
        n_checks++; if (valid0 !== 1'b0 || cnt0 !== 2'd0) begin n_fail++; $display("FAIL single_drain_lat0 got valid %b cnt %0d exp 0 0", valid0, cnt0); end
        n_checks++; if (valid1 !== 1'b0 || cnt1 !== 2'd0) begin n_fail++; $display("FAIL single_drain_lat1 got valid %b cnt %0d exp 0 0", valid1, cnt1); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) push_both(8'h20 + W'(i));
        tick();
        tick();
        // Everything already read from the FIFO is discarded by the flush.
        flush = 1'b1;
        exp0 = q0; exp1 = q1;
        tick();
        flush = 1'b0;
        n_checks++; if (last_re0 !== 1'b0 || last_re1 !== 1'b0) begin n_fail++; $display("FAIL flush_rd_en got %b%b exp 00", last_re0, last_re1); end
        n_checks++; if (valid0 !== 1'b0 || cnt0 !== 2'd0) begin n_fail++; $display("FAIL flush_empty_lat0 got valid %b cnt %0d exp 0 0", valid0, cnt0); end
        n_checks++; if (valid1 !== 1'b0 || cnt1 !== 2'd0) begin n_fail++; $display("FAIL flush_empty_lat1 got valid %b cnt %0d exp 0 0", valid1, cnt1); end
        out_ready = 1'b1;
        repeat (8) tick();
        n_checks++; if (got1.size() == 0 || got1[0] !== 8'h22) begin n_fail++; $display("FAIL flush_next_lat1 got %0d words exp first 22", got1.size()); end
        n_checks++; if (got0.size() != exp0.size()) begin n_fail++; $display("FAIL flush_count_lat0 got %0d exp %0d", got0.size(), exp0.size()); end
        n_checks++; if (got1.size() != exp1.size()) begin n_fail++; $display("FAIL flush_count_lat1 got %0d exp %0d", got1.size(), exp1.size()); end
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            n_checks++; if (got0[i] !== exp0[i]) begin n_fail++; $display("FAIL flush_word_lat0[%0d] got %h exp %h", i, got0[i], exp0[i]); end
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            n_checks++; if (got1[i] !== exp1[i]) begin n_fail++; $display("FAIL flush_word_lat1[%0d] got %h exp %h", i, got1[i], exp1[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 8; i++) push_both(8'h30 + W'(i));
        tick();
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        n_checks++; if (last_re0 !== 1'b0 || last_re1 !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en got %b%b exp 00", last_re0, last_re1); end
        n_checks++; if (valid0 !== 1'b0 || data0 !== 8'h00 || cnt0 !== 2'd0) begin n_fail++; $display("FAIL midrst_out_lat0 got %b %h %0d exp 0 00 0", valid0, data0, cnt0); end
        n_checks++; if (valid1 !== 1'b0 || data1 !== 8'h00 || cnt1 !== 2'd0) begin n_fail++; $display("FAIL midrst_out_lat1 got %b %h %0d exp 0 00 0", valid1, data1, cnt1); end
        exp0 = q0; exp1 = q1;
        clear_log();
        out_ready = 1'b1;
        repeat (12) tick();
        n_checks++; if (got0.size() != exp0.size()) begin n_fail++; $display("FAIL midrst_count_lat0 got %0d exp %0d", got0.size(), exp0.size()); end
        n_checks++; if (got1.size() != exp1.size()) begin n_fail++; $display("FAIL midrst_count_lat1 got %0d exp %0d", got1.size(), exp1.size()); end
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            n_checks++; if (got0[i] !== exp0[i]) begin n_fail++; $display("FAIL midrst_word_lat0[%0d] got %h exp %h", i, got0[i], exp0[i]); end
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            n_checks++; if (got1[i] !== exp1[i]) begin n_fail++; $display("FAIL midrst_word_lat1[%0d] got %h exp %h", i, got1[i], exp1[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        int over0, over1, bad0, bad1, guard;
        logic [W-1:0] w;
        do_reset();
        over0 = 0; over1 = 0; bad0 = 0; bad1 = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 60) begin
                w = W'($urandom_range(0, 255));
                exp_q.push_back(w);
                push_both(w);
            end
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
            if (cnt0 > 2'd2) over0++;
            if (cnt1 > 2'd2) over1++;
        end
        out_ready = 1'b1;
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0 || valid0 || valid1 || rd_en1) && guard < 1000) begin
            tick();
            guard++;
        end
        n_checks++; if (guard >= 1000) begin n_fail++; $display("FAIL rand_drain_timeout got %0d cycles exp < 1000", guard); end
        n_checks++; if (over0 != 0 || over1 != 0) begin n_fail++; $display("FAIL rand_cnt_range got %0d/%0d exp 0/0", over0, over1); end
        n_checks++; if (stall_err0 != 0 || stall_err1 != 0) begin n_fail++; $display("FAIL rand_stall_hold got %0d/%0d exp 0/0", stall_err0, stall_err1); end
        n_checks++; if (got0.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count_lat0 got %0d exp %0d", got0.size(), exp_q.size()); end
        n_checks++; if (got1.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count_lat1 got %0d exp %0d", got1.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got0.size() && got0[i] !== exp_q[i]) bad0++;
            if (i < got1.size() && got1[i] !== exp_q[i]) bad1++;
        end
        n_checks++; if (bad0 != 0) begin n_fail++; $display("FAIL rand_order_lat0 got %0d wrong words exp 0", bad0); end
        n_checks++; if (bad1 != 0) begin n_fail++; $display("FAIL rand_order_lat1 got %0d wrong words exp 0", bad1); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        clear_log();
        test_reset();
        test_stream();
        test_backpressure();
        test_single_word();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
